// File: rtl/clock_ratio_decoder.sv
// clock_ratio_decoder
//   Measures the half-period of an asynchronous divided clock (clk_in) in
//   system-clock cycles and decodes which divider code produced it, using the
//   multiplier table 1,2,4,10,16,32,64,128 and expected half-period
//   H(k) = COUNT_10*M(k) + 1. Lock is declared after LOCK_COUNT consecutive
//   matches of the same code.
// Ports
//   clock        in   system clock
//   reset        in   asynchronous, active-high
//   clk_in       in   divided clock to measure (asynchronous)
//   clear        in   synchronous restart: drop lock, return to IDLE
//   prog_code    out  decoded divider code (meaningful while locked)
//   locked       out  decoded rate is stable
//   code_valid   out  1-cycle pulse on lock rise or code change while locked
//   half_period  out  last measured half-period in cycles
//   stall        out  sticky: no clk_in edge within H(7)+TOL cycles
module clock_ratio_decoder #(
    parameter int COUNT_10   = 5_000_000,
    parameter int TOL        = 1024,
    parameter int LOCK_COUNT = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             clear,
    output logic [2:0]       prog_code,
    output logic             locked,
    output logic             code_valid,
    output logic [CNT_W-1:0] half_period,
    output logic             stall
);

    localparam int RUN_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0] LOCK_N = RUN_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] TOL_V  = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(COUNT_10 * 128 + 1 + TOL);

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;

    function automatic logic [CNT_W-1:0] h_of(input int k);
        int m;
        case (k)
            0:       m = 1;
            1:       m = 2;
            2:       m = 4;
            3:       m = 10;
            4:       m = 16;
            5:       m = 32;
            6:       m = 64;
            default: m = 128;
        endcase
        return CNT_W'(COUNT_10 * m + 1);
    endfunction

    // Returns {match, code}; scanning downward lets the lowest matching k win.
    function automatic logic [3:0] classify(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] d;
        logic [3:0]       r;
        r = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            h = h_of(k);
            d = (v > h) ? (v - h) : (h - v);
            if (d <= TOL_V) r = {1'b1, 3'(k)};
        end
        return r;
    endfunction

    logic             r_sync1, r_sync2, r_sync_d;
    logic             w_evt, w_idle, w_timeout;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half_period;
    logic             r_vld_p1, r_vld_p2;
    logic             r_match_p2;
    logic [2:0]       r_code_p2;
    logic [3:0]       w_cls;
    logic             r_stall;
    state_t           r_state, w_nxt_state;
    logic [RUN_W-1:0] r_run, w_nxt_run, w_run_new;
    logic [2:0]       r_cand, w_nxt_cand, w_cand_new;
    logic [2:0]       r_prog, w_nxt_prog;
    logic             r_cv, w_nxt_cv;

    assign w_evt     = r_sync2 ^ r_sync_d;
    assign w_idle    = (r_state == S_IDLE);
    // A coinciding edge wins over the timeout; an edge that late arrives in IDLE anyway.
    assign w_timeout = (r_cnt > LIMIT) && !w_evt;
    assign w_cls     = classify(r_half_period);

    // Stage p0: synchronizer, edge detect, period counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= clk_in;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            if (w_evt && !clear)
                r_cnt <= CNT_W'(1);
            else if (r_cnt != '1)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Stage p1: capture the measured half-period; stall tracking
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_half_period <= '0;
            r_vld_p1      <= 1'b0;
            r_vld_p2      <= 1'b0;
            r_stall       <= 1'b0;
        end else begin
            r_vld_p1 <= !clear && w_evt && !w_idle;
            r_vld_p2 <= r_vld_p1 && !clear;
            if (!clear && w_evt && !w_idle)
                r_half_period <= r_cnt;
            if (clear)
                r_stall <= 1'b0;
            else if (w_evt && w_idle)
                r_stall <= 1'b0;
            else if (w_timeout)
                r_stall <= 1'b1;
        end
    end

    // Stage p2: classification result
    always_ff @(posedge clock) begin
        r_match_p2 <= w_cls[3];
        r_code_p2  <= w_cls[2:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_run   <= '0;
            r_cand  <= 3'd0;
            r_prog  <= 3'd0;
            r_cv    <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_run   <= w_nxt_run;
            r_cand  <= w_nxt_cand;
            r_prog  <= w_nxt_prog;
            r_cv    <= w_nxt_cv;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_run   = r_run;
        w_nxt_cand  = r_cand;
        w_nxt_prog  = r_prog;
        w_nxt_cv    = 1'b0;
        w_run_new   = r_run;
        w_cand_new  = r_cand;
        if (clear || w_timeout) begin
            w_nxt_state = S_IDLE;
            w_nxt_run   = '0;
        end else if (w_idle) begin
            if (w_evt) w_nxt_state = S_ACQ;
        end else if (r_vld_p2) begin
            if (!r_match_p2) begin
                w_nxt_state = S_ACQ;
                w_nxt_run   = '0;
            end else if (r_state == S_LOCKED && r_code_p2 == r_prog) begin
                w_nxt_state = S_LOCKED;
            end else begin
                if (r_state == S_ACQ && r_code_p2 == r_cand) begin
                    w_run_new  = r_run + RUN_W'(1);
                    w_cand_new = r_cand;
                end else begin
                    w_run_new  = RUN_W'(1);
                    w_cand_new = r_code_p2;
                end
                w_nxt_run  = w_run_new;
                w_nxt_cand = w_cand_new;
                if (w_run_new >= LOCK_N) begin
                    w_nxt_state = S_LOCKED;
                    w_nxt_prog  = w_cand_new;
                    w_nxt_cv    = 1'b1;
                end else begin
                    w_nxt_state = S_ACQ;
                end
            end
        end
    end

    always_comb begin
        locked      = (r_state == S_LOCKED);
        prog_code   = r_prog;
        code_valid  = r_cv;
        half_period = r_half_period;
        stall       = r_stall;
    end

endmodule

// File: tb/tb_clock_ratio_decoder.sv
module tb_clock_ratio_decoder;

    localparam int COUNT_10   = 8;
    localparam int TOL        = 1;
    localparam int LOCK_COUNT = 2;
    localparam int CNT_W      = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             clk_in = 1'b0;
    logic             clear = 1'b0;
    logic [2:0]       prog_code;
    logic             locked;
    logic             code_valid;
    logic [CNT_W-1:0] half_period;
    logic             stall;

    clock_ratio_decoder #(
        .COUNT_10(COUNT_10), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .clk_in(clk_in), .clear(clear),
        .prog_code(prog_code), .locked(locked), .code_valid(code_valid),
        .half_period(half_period), .stall(stall)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;
    int cv_cnt = 0;

    int M_TAB [8] = '{1, 2, 4, 10, 16, 32, 64, 128};

    function automatic int h_exp(int k);
        return COUNT_10 * M_TAB[k] + 1;
    endfunction

    function automatic int m_classify(int v);
        int d;
        for (int k = 0; k < 8; k++) begin
            d = (v > h_exp(k)) ? v - h_exp(k) : h_exp(k) - v;
            if (d <= TOL) return k;
        end
        return -1;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: tracks the list of classified measurements since the
    // last restart; locked means the newest LOCK_COUNT entries share one code.
    int  m_cnt = 0;
    bit  m_s1 = 0, m_s2 = 0, m_sd = 0;
    bit  m_idle = 1;
    bit  m_stall = 0, m_locked = 0, m_cv = 0;
    int  m_prog = 0, m_hp = 0;
    int  hist[$];
    bit  m_pv = 0;
    int  m_pdue = 0, m_pcode = 0, m_edge = 0;
    int  LIMIT;
    int  CMAX;

    initial begin
        LIMIT = h_exp(7) + TOL;
        CMAX  = (1 << CNT_W) - 1;
    end

    task automatic update_lock();
        int  c;
        bit  same;
        same = 0;
        c = -1;
        if (hist.size() >= LOCK_COUNT) begin
            c = hist[hist.size() - 1];
            same = (c >= 0);
            for (int i = 0; i < LOCK_COUNT; i++)
                if (hist[hist.size() - 1 - i] != c) same = 0;
        end
        if (same && (!m_locked || c != m_prog)) begin
            m_cv = 1;
            m_prog = c;
        end
        m_locked = same;
    endtask

    always @(posedge clock or posedge reset) begin : model
        bit evt;
        if (reset) begin
            m_cnt = 0; m_s1 = 0; m_s2 = 0; m_sd = 0; m_idle = 1;
            m_stall = 0; m_locked = 0; m_cv = 0; m_prog = 0; m_hp = 0;
            hist.delete(); m_pv = 0;
        end else begin
            evt = (m_s2 != m_sd);
            m_sd = m_s2; m_s2 = m_s1; m_s1 = clk_in;
            m_edge++;
            m_cv = 0;
            if (clear) begin
                m_idle = 1; m_stall = 0; m_locked = 0; hist.delete(); m_pv = 0;
                if (m_cnt < CMAX) m_cnt++;
            end else begin
                if (m_pv && m_pdue == m_edge) begin
                    m_pv = 0;
                    hist.push_back(m_pcode);
                    update_lock();
                end
                if (evt) begin
                    if (m_idle) begin
                        m_idle = 0; m_stall = 0;
                    end else begin
                        m_hp = m_cnt; m_pv = 1; m_pdue = m_edge + 2;
                        m_pcode = m_classify(m_cnt);
                    end
                    m_cnt = 1;
                end else begin
                    if (m_cnt > LIMIT) begin
                        m_stall = 1; m_idle = 1; m_locked = 0; hist.delete();
                    end
                    if (m_cnt < CMAX) m_cnt++;
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("locked", int'(locked), int'(m_locked));
        chk("prog_code", int'(prog_code), m_prog);
        chk("code_valid", int'(code_valid), int'(m_cv));
        chk("half_period", int'(half_period), m_hp);
        chk("stall", int'(stall), int'(m_stall));
        if (code_valid) cv_cnt++;
    end

    task automatic toggle(int half, int n);
        for (int i = 0; i < n; i++) begin
            repeat (half) @(posedge clock);
            #1 clk_in = ~clk_in;
        end
    endtask

    task automatic settle();
        repeat (6) @(posedge clock);
        #2;
    endtask

    initial begin
        int k, sp, reps;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Square wave of half-period 33: lock on the second full measurement
        cv_cnt = 0;
        toggle(33, 2);
        settle();
        chk("t1_hp", int'(half_period), 33);
        chk("t1_not_yet", int'(locked), 0);
        toggle(27, 1);
        settle();
        chk("t1_locked", int'(locked), 1);
        chk("t1_code", int'(prog_code), 2);
        chk("t1_cv_pulses", cv_cnt, 1);

        // 34 stays within tolerance, 36 drops lock silently
        cv_cnt = 0;
        toggle(28, 1);
        toggle(34, 1);
        settle();
        chk("t2_hp34", int'(half_period), 34);
        chk("t2_still_locked", int'(locked), 1);
        toggle(30, 1);
        settle();
        chk("t2_hp36", int'(half_period), 36);
        chk("t2_dropped", int'(locked), 0);
        chk("t2_code_hold", int'(prog_code), 2);
        chk("t2_no_cv", cv_cnt, 0);

        // Lock at 9 (code 0), then move to 1025 (code 7)
        toggle(3, 1);
        toggle(9, 1);
        settle();
        chk("t3_code0", int'(prog_code), 0);
        chk("t3_locked0", int'(locked), 1);
        cv_cnt = 0;
        toggle(1019, 1);
        settle();
        chk("t3_drop", int'(locked), 0);
        toggle(1019, 1);
        settle();
        chk("t3_locked7", int'(locked), 1);
        chk("t3_code7", int'(prog_code), 7);
        chk("t3_cv_pulses", cv_cnt, 1);

        // Static input: stall, then recover at 17
        repeat (1100) @(posedge clock);
        #2;
        chk("t4_stall", int'(stall), 1);
        chk("t4_unlocked", int'(locked), 0);
        toggle(17, 1);
        settle();
        chk("t4_stall_clr", int'(stall), 0);
        toggle(11, 1);
        toggle(17, 1);
        settle();
        chk("t4_locked1", int'(locked), 1);
        chk("t4_code1", int'(prog_code), 1);

        // clear coincident with an edge while locked
        toggle(11, 1);
        repeat (17) @(posedge clock);
        #1 clk_in = ~clk_in;
        @(posedge clock);
        @(posedge clock);
        #1 clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        #1;
        chk("t5_clear_drop", int'(locked), 0);
        chk("t5_hp_hold", int'(half_period), 17);
        toggle(14, 1);
        toggle(17, 1);
        settle();
        chk("t5_one_meas", int'(locked), 0);
        toggle(11, 1);
        settle();
        chk("t5_relock", int'(locked), 1);

        // reset mid-period while locked
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("t6_locked", int'(locked), 0);
        chk("t6_code", int'(prog_code), 0);
        chk("t6_hp", int'(half_period), 0);
        chk("t6_stall", int'(stall), 0);
        chk("t6_cv", int'(code_valid), 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        cv_cnt = 0;
        repeat (20) @(posedge clock);
        #2;
        chk("t6_no_cv", cv_cnt, 0);

        // Randomized runs of near-nominal periods, occasional outliers and clears
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 7);
            reps = $urandom_range(1, 4);
            for (int r = 0; r < reps; r++) begin
                if ($urandom_range(0, 9) == 0)
                    sp = $urandom_range(7, 1100);
                else
                    sp = h_exp(k) + $urandom_range(0, 4) - 2;
                toggle(sp, 1);
            end
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 5)) @(posedge clock);
                #1 clear = 1'b1;
                @(posedge clock);
                #1 clear = 1'b0;
            end
        end

        repeat (10) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
